uart_fifo: RTL
==============

# uart_fifo

Parametrised UART peripheral with the same byte-wide, request/data-valid register interface as the current UART register block. It adds real 8N1 serial transmit and receive engines, depth-configurable TX and RX FIFOs, line-status flags and an interrupt output. It sits on the CPU's memory-mapped I/O bus and drives the board's serial pins.

## Interface
- CLKS_PER_BIT, 16: system clocks per serial bit; minimum 4.
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..256.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  reset: asynchronous assert, active-low; release synchronised internally.
- i_data  in  8  write data.
- i_address  in  3  register select.
- i_write  in  1  1 = write, 0 = read; qualified by i_request.
- i_request  in  1  single-cycle bus access strobe.
- o_data  out  8  read data, registered.
- o_data_DV  out  1  access acknowledge pulse.
- i_rx  in  1  serial input; idle high; asynchronous, double-flopped internally.
- o_tx  out  1  serial output; idle high.
- o_irq  out  1  level interrupt.

## Operation
- Register map:
  - 0: read RHR pops the RX FIFO; write THR pushes the TX FIFO.
  - 1: IER. Bit0 enables the RX-data interrupt, bit1 the TX-empty interrupt. Bits 7:2 read 0.
  - 2: read ISR, where bit0 = no interrupt pending, bit1 = TX empty, bit2 = RX data. Writes go to FCR, where bit1 flushes RX and bit2 flushes TX (self-clearing).
  - 3: LCR, a scratch register, read/write.
  - 4: MCR (see Configuration).
  - 5: LSR, read-only. Bit0 = RX FIFO not empty, bit1 = overrun, bit3 = framing error, bit5 = TX FIFO empty, bit6 = TX FIFO empty and serializer idle.
  - 6-7: read 0, writes ignored.
- Reading LSR clears bits 1 and 3.
- o_irq = (IER[0] & LSR[0]) | (IER[1] & LSR[5]).
- TX engine:
  - States: IDLE, START, DATA, STOP.
  - In IDLE with the FIFO non-empty, pop one byte and enter START.
  - Send one start bit (0), then 8 data bits LSB first, then one stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
  - From STOP, go directly to START if the FIFO is non-empty, with no idle gap; otherwise return to IDLE.
- RX engine:
  - States: IDLE, START, DATA, STOP.
  - A falling edge on the synchronised input enters START.
  - At CLKS_PER_BIT/2 the input is re-checked: if it is high, treat it as a glitch and return to IDLE.
  - Data bits are sampled at the middle of each bit, CLKS_PER_BIT apart.
  - At the stop-bit sample: push the byte. If the stop bit is 0, push the byte anyway and set FE.
  - If the FIFO is full at the stop-bit sample, drop the byte and set OE.
- Boundary conditions:
  - THR write while the TX FIFO is full: data dropped; still acknowledged.
  - RHR read while the RX FIFO is empty: returns 0x00; no pop.
  - RX push and RHR pop in the same cycle: both take effect; the count is unchanged.
  - TX flush while the serializer is busy: the current frame completes; queued bytes are discarded.
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the extra bit.

## Timing
- Reset values:
  - o_data = 0, o_data_DV = 0, o_tx = 1, o_irq = 0.
  - All registers 0.
  - Both FIFOs empty; both engines IDLE.
  - Assertion mid-frame aborts the frame immediately, forcing o_tx = 1 asynchronously.
- Bus access:
  - i_request sampled in cycle N gives o_data_DV = 1 for exactly cycle N+1.
  - For a read, o_data holds the register value as sampled in cycle N, valid during N+1.
  - Writes and pops take effect at the edge ending cycle N.
  - Back-to-back requests on consecutive cycles are supported.
- TX timing:
  - A THR write into an empty, idle TX path drives o_tx low 2 clocks after the request edge.
  - One frame lasts 10 × CLKS_PER_BIT clocks.
- RX timing:
  - LSR[0] rises at most 3 clocks after the mid-stop-bit sample (includes the 2-flop synchroniser).
- o_irq is registered and updates 1 clock after its sources change.

## Configuration
- UART_LOOPBACK_EN:
  - Defined: MCR is a read/write register at address 4.
  - With MCR bit4 = 1, the TX serializer output feeds the RX engine in place of i_rx, and o_tx is held at 1.
  - Other MCR bits are storage only.
- Not defined: address 4 reads 0, writes are ignored, and the loopback path is absent.

## Test plan
- Reset: assert i_rst_n low mid-frame → o_tx = 1 immediately; LSR reads 0x60; o_irq = 0.
- TX: write 0x55 to THR with CLKS_PER_BIT = 16 → o_tx shows start bit 0, then 1,0,1,0,1,0,1,0 (LSB first), then stop bit 1, each bit 16 clocks; then LSR[6] = 1.
- RX: drive 0xA3 serially on i_rx → LSR[0] = 1, RHR reads 0xA3, then LSR[0] = 0.
- Overrun: receive FIFO_DEPTH+1 bytes without reading → LSR = 0x63. The first LSR read clears OE, so the second LSR read returns 0x61. RHR returns only the first FIFO_DEPTH bytes.
- Framing: send 0x7E with the stop bit forced to 0 → RHR = 0x7E; LSR[3] = 1 until the next LSR read.
- Interrupt and loopback (macro defined): IER = 0x01, MCR = 0x10, write THR 0xC4 → o_irq rises; RHR = 0xC4; o_tx stays 1 throughout.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: byte-wide register-mapped UART with 8N1 TX/RX engines, TX/RX FIFOs and a level interrupt.
// Define UART_LOOPBACK_EN to add the MCR register and the internal TX->RX loopback path.

module uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB tells a full buffer apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// state    | meaning
// TX_IDLE  | line high, waiting for a byte in the TX FIFO
// TX_START | driving the start bit (0)
// TX_DATA  | shifting out 8 data bits, LSB first
// TX_STOP  | driving the stop bit (1); chains straight into the next frame
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit; high there means a glitch
// RX_DATA  | sampling 8 data bits at mid-bit
// RX_STOP  | counting to mid stop bit, then push / flag FE or OE
module uart_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic [2:0] i_address,
  input  logic       i_write,
  input  logic       i_request,
  output logic [7:0] o_data,
  output logic       o_data_DV,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [1:0] rst_sync;
  logic       rst_n;

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic       wr_req, rd_req;
  logic       thr_push, rhr_pop, lsr_read;
  logic       tx_flush, rx_flush;
  logic [1:0] ier;
  logic [7:0] lcr;
  logic [7:0] mcr;
  logic       loop_en;
  logic       oe, fe;
  logic [7:0] rd_mux;
  logic [7:0] lsr;
  logic       rx_irq, tx_irq;

  logic       tx_empty, tx_full, tx_pop, tx_avail;
  logic [7:0] tx_rdata;
  logic       rx_empty, rx_full;
  logic [7:0] rx_rdata;

  tx_state_t  tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit_idx;
  logic [7:0] tx_shift;
  logic       tx_line;

  rx_state_t  rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit_idx;
  logic [7:0] rx_shift;
  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_in;
  logic       rx_src;
  logic       rx_stop_tick;

  assign wr_req   = i_request && i_write;
  assign rd_req   = i_request && !i_write;
  assign thr_push = wr_req && (i_address == 3'd0) && !tx_full;
  assign rhr_pop  = rd_req && (i_address == 3'd0);
  assign lsr_read = rd_req && (i_address == 3'd5);
  assign rx_flush = wr_req && (i_address == 3'd2) && i_data[1];
  assign tx_flush = wr_req && (i_address == 3'd2) && i_data[2];

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)                             mcr <= 8'h00;
    else if (wr_req && i_address == 3'd4)   mcr <= i_data;
  end
`else
  assign mcr = 8'h00;
`endif
  assign loop_en = mcr[4];

  assign rx_irq = ier[0] && !rx_empty;
  assign tx_irq = ier[1] && tx_empty;
  assign lsr    = {1'b0, tx_empty && (tx_state == TX_IDLE), tx_empty, 1'b0, fe, 1'b0, oe, !rx_empty};

  always_comb begin
    rd_mux = 8'h00;
    case (i_address)
      3'd0:    rd_mux = rx_empty ? 8'h00 : rx_rdata;
      3'd1:    rd_mux = {6'b0, ier};
      3'd2:    rd_mux = {5'b0, rx_irq, tx_irq, !(rx_irq || tx_irq)};
      3'd3:    rd_mux = lcr;
      3'd4:    rd_mux = mcr;
      3'd5:    rd_mux = lsr;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data    <= 8'h00;
      o_data_DV <= 1'b0;
      ier       <= 2'b00;
      lcr       <= 8'h00;
      o_irq     <= 1'b0;
    end else begin
      o_data_DV <= i_request;
      o_irq     <= rx_irq || tx_irq;
      if (rd_req) o_data <= rd_mux;
      if (wr_req && i_address == 3'd1) ier <= i_data[1:0];
      if (wr_req && i_address == 3'd3) lcr <= i_data;
    end
  end

  // A set in the same cycle as the clearing LSR read wins.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      oe <= 1'b0;
      fe <= 1'b0;
    end else begin
      if (rx_stop_tick && rx_full && !rhr_pop) oe <= 1'b1;
      else if (lsr_read)                       oe <= 1'b0;
      if (rx_stop_tick && !rx_in)              fe <= 1'b1;
      else if (lsr_read)                       fe <= 1'b0;
    end
  end

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .flush (tx_flush),
    .push  (thr_push),
    .pop   (tx_pop),
    .wdata (i_data),
    .rdata (tx_rdata),
    .empty (tx_empty),
    .full  (tx_full)
  );

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .flush (rx_flush),
    .push  (rx_stop_tick),
    .pop   (rhr_pop),
    .wdata (rx_shift),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign tx_avail = !tx_empty && !tx_flush;
  assign tx_pop   = tx_avail && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));

  // tx_line lags the state by one clock uniformly, so every bit keeps its full width.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit_idx <= 3'd0;
      tx_shift   <= 8'h00;
      tx_line    <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (tx_avail) begin
            tx_shift <= tx_rdata;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx_line <= 1'b0;
          if (tx_cnt == '0) begin
            tx_cnt     <= BIT_LAST;
            tx_bit_idx <= 3'd0;
            tx_state   <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          tx_line <= tx_shift[0];
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_LAST;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit_idx == 3'd7) tx_state <= TX_STOP;
            else                    tx_bit_idx <= tx_bit_idx + 1'b1;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          tx_line <= 1'b1;
          if (tx_cnt == '0) begin
            if (tx_avail) begin
              tx_shift <= tx_rdata;
              tx_cnt   <= BIT_LAST;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign o_tx = tx_line || loop_en;

  assign rx_src       = loop_en ? tx_line : i_rx;
  assign rx_in        = rx_sync[1];
  assign rx_stop_tick = (rx_state == RX_STOP) && (rx_cnt == '0);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync    <= 2'b11;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit_idx <= 3'd0;
      rx_shift   <= 8'h00;
    end else begin
      rx_sync <= {rx_sync[0], rx_src};
      rx_prev <= rx_in;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_in) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt     <= BIT_LAST;
              rx_bit_idx <= 3'd0;
              rx_state   <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= BIT_LAST;
            rx_shift <= {rx_in, rx_shift[7:1]};
            if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
            else                    rx_bit_idx <= rx_bit_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule
